// File: rtl/max_pooler.sv
`default_nettype none
// ============================================================================
// Module   : max_pooler
// Purpose  : Streaming PxP max-pooling of a row-major NxN feature map using a
//            line buffer of N/P partial maxima. Optional MAX_POOLER_RELU_EN
//            clamps negative inputs to zero before pooling.
// Revision : 1.0 - initial release
// ============================================================================
module max_pooler #(
    parameter int dataWidth = 8,
    parameter int N         = 56,
    parameter int P         = 2
) (
    input  logic                 clk,
    input  logic                 global_rst,
    input  logic                 ce,
    input  logic                 valid_in,
    input  logic                 end_in,
    input  logic [dataWidth-1:0] data_in,
    output logic [dataWidth-1:0] pool_op,
    output logic                 valid_pool,
    output logic                 end_pool
);

    localparam int NW = N / P;
    localparam int NF = NW * P;
    localparam int CW = (N > 1) ? $clog2(N) : 1;
    localparam int PW = $clog2(P);
    localparam int WW = (NW > 1) ? $clog2(NW) : 1;
    localparam int LD = 1 << WW;

    logic [CW-1:0]               col_q, col_d, row_q, row_d;
    logic [PW-1:0]               hph_q, hph_d, vph_q, vph_d;
    logic [WW-1:0]               wcol_q, wcol_d, wrow_q, wrow_d;
    logic signed [dataWidth-1:0] hmax_q, hmax_d;
    logic [dataWidth-1:0]        pool_q, pool_d;
    logic                        valid_q, valid_d, end_q, end_d;

    logic signed [dataWidth-1:0] lbuf_q [LD];
    logic                        lbuf_we;
    logic signed [dataWidth-1:0] lbuf_wd;

    logic                        accept, in_region, win_done;
    logic signed [dataWidth-1:0] din, hmerge, lmerge;

    function automatic logic signed [dataWidth-1:0] smax(
        input logic signed [dataWidth-1:0] a,
        input logic signed [dataWidth-1:0] b
    );
        return (a > b) ? a : b;
    endfunction

    always_comb begin
`ifdef MAX_POOLER_RELU_EN
        din = data_in[dataWidth-1] ? '0 : $signed(data_in);
`else
        din = $signed(data_in);
`endif
    end

    always_comb begin
        accept    = ce && valid_in && !end_in;
        // Floor mode: trailing columns/rows beyond the last full window are dropped.
        in_region = (32'(col_q) < 32'(NF)) && (32'(row_q) < 32'(NF));
        win_done  = accept && in_region && (hph_q == PW'(P - 1));
        hmerge    = smax(hmax_q, din);
        lmerge    = smax(lbuf_q[wcol_q], hmerge);

        col_d   = col_q;
        row_d   = row_q;
        hph_d   = hph_q;
        vph_d   = vph_q;
        wcol_d  = wcol_q;
        wrow_d  = wrow_q;
        hmax_d  = hmax_q;
        pool_d  = pool_q;
        valid_d = 1'b0;
        end_d   = 1'b0;
        lbuf_we = 1'b0;
        lbuf_wd = hmerge;

        if (ce && end_in) begin
            col_d  = '0;
            row_d  = '0;
            hph_d  = '0;
            vph_d  = '0;
            wcol_d = '0;
            wrow_d = '0;
            hmax_d = '0;
        end else if (accept) begin
            hmax_d = (hph_q == '0) ? din : hmerge;

            if (col_q == CW'(N - 1)) begin
                col_d  = '0;
                hph_d  = '0;
                wcol_d = '0;
                if (row_q == CW'(N - 1)) begin
                    row_d  = '0;
                    vph_d  = '0;
                    wrow_d = '0;
                end else begin
                    row_d = row_q + CW'(1);
                    if (vph_q == PW'(P - 1)) begin
                        vph_d  = '0;
                        wrow_d = wrow_q + WW'(1);
                    end else begin
                        vph_d = vph_q + PW'(1);
                    end
                end
            end else begin
                col_d = col_q + CW'(1);
                if (hph_q == PW'(P - 1)) begin
                    hph_d  = '0;
                    wcol_d = wcol_q + WW'(1);
                end else begin
                    hph_d = hph_q + PW'(1);
                end
            end

            if (win_done) begin
                if (vph_q == '0) begin
                    lbuf_we = 1'b1;
                    lbuf_wd = hmerge;
                end else if (vph_q != PW'(P - 1)) begin
                    lbuf_we = 1'b1;
                    lbuf_wd = lmerge;
                end else begin
                    pool_d  = lmerge;
                    valid_d = 1'b1;
                    end_d   = (wrow_q == WW'(NW - 1)) && (wcol_q == WW'(NW - 1));
                end
            end
        end
    end

    always_ff @(posedge clk or posedge global_rst) begin
        if (global_rst) begin
            col_q   <= '0;
            row_q   <= '0;
            hph_q   <= '0;
            vph_q   <= '0;
            wcol_q  <= '0;
            wrow_q  <= '0;
            hmax_q  <= '0;
            pool_q  <= '0;
            valid_q <= 1'b0;
            end_q   <= 1'b0;
        end else begin
            col_q   <= col_d;
            row_q   <= row_d;
            hph_q   <= hph_d;
            vph_q   <= vph_d;
            wcol_q  <= wcol_d;
            wrow_q  <= wrow_d;
            hmax_q  <= hmax_d;
            pool_q  <= pool_d;
            valid_q <= valid_d;
            end_q   <= end_d;
        end
    end

    // Every entry is rewritten on window row 0 before it is read, so no reset.
    always_ff @(posedge clk) begin
        if (lbuf_we) begin
            lbuf_q[wcol_q] <= lbuf_wd;
        end
    end

    assign pool_op    = pool_q;
    assign valid_pool = valid_q;
    assign end_pool   = end_q;

endmodule
`default_nettype wire

// File: tb/tb_max_pooler.sv
`default_nettype none
// ============================================================================
// Module   : tb_max_pooler
// Purpose  : Self-checking bench for max_pooler (N=4 and N=5, P=2); honours
//            MAX_POOLER_RELU_EN when it is defined for the build.
// Revision : 1.0 - initial release
// ============================================================================
module tb_max_pooler;

    localparam int PB = 2;

    logic       clk = 1'b0;
    logic       rst, ce, end_in, v4, v5;
    logic [7:0] din;
    logic [7:0] pool4, pool5;
    logic       vp4, ep4, vp5, ep5;

    always #5 clk = ~clk;

    max_pooler #(.dataWidth(8), .N(4), .P(2)) dut4 (
        .clk(clk), .global_rst(rst), .ce(ce), .valid_in(v4), .end_in(end_in),
        .data_in(din), .pool_op(pool4), .valid_pool(vp4), .end_pool(ep4)
    );

    max_pooler #(.dataWidth(8), .N(5), .P(2)) dut5 (
        .clk(clk), .global_rst(rst), .ce(ce), .valid_in(v5), .end_in(end_in),
        .data_in(din), .pool_op(pool5), .valid_pool(vp5), .end_pool(ep5)
    );

    int checks   = 0;
    int failures = 0;

    // Reference model: position counters plus a stored image; a result is the
    // max over the completed PBxPB window, evaluated when its last sample lands.
    int         mcol [2];
    int         mrow [2];
    int         img  [2][5][5];
    logic       ev   [2];
    logic       ee   [2];
    logic [7:0] ep   [2];

    logic [8:0] q4 [$];
    logic [8:0] q5 [$];

    typedef struct {
        logic [7:0] d;
        logic       ev;
        logic       ee;
        logic [7:0] ep;
    } vec_t;
    vec_t tbl [64];

    always @(negedge clk) begin
        if (vp4) q4.push_back({ep4, pool4});
        if (vp5) q5.push_back({ep5, pool5});
    end

    task automatic chk(input string nm, input int act, input int exp);
        checks++;
        if (act != exp) begin
            failures++;
            $display("FAIL %s: got %0d expected %0d (t=%0t)", nm, act, exp, $time);
        end
    endtask

    function automatic logic [7:0] relu_f(input logic [7:0] x);
`ifdef MAX_POOLER_RELU_EN
        return x[7] ? 8'h00 : x;
`else
        return x;
`endif
    endfunction

    task automatic model_reset();
        for (int d = 0; d < 2; d++) begin
            mcol[d] = 0;
            mrow[d] = 0;
            ev[d]   = 1'b0;
            ee[d]   = 1'b0;
            ep[d]   = 8'h00;
        end
    endtask

    task automatic model_edge(input int d, input int n, input logic v, input logic c,
                              input logic e, input logic [7:0] x);
        int nw, mx;
        ev[d] = 1'b0;
        ee[d] = 1'b0;
        if (!c) return;
        if (e) begin
            mcol[d] = 0;
            mrow[d] = 0;
            return;
        end
        if (!v) return;
        nw = n / PB;
        img[d][mrow[d]][mcol[d]] = int'($signed(relu_f(x)));
        if ((mrow[d] % PB == PB - 1) && (mcol[d] % PB == PB - 1) &&
            (mrow[d] < nw * PB) && (mcol[d] < nw * PB)) begin
            mx = -1000;
            for (int dr = 0; dr < PB; dr++)
                for (int dc = 0; dc < PB; dc++)
                    if (img[d][mrow[d]-dr][mcol[d]-dc] > mx)
                        mx = img[d][mrow[d]-dr][mcol[d]-dc];
            ev[d] = 1'b1;
            ep[d] = mx[7:0];
            ee[d] = (mrow[d] == nw * PB - 1) && (mcol[d] == nw * PB - 1);
        end
        mcol[d]++;
        if (mcol[d] == n) begin
            mcol[d] = 0;
            mrow[d]++;
            if (mrow[d] == n) mrow[d] = 0;
        end
    endtask

    task automatic check_outputs();
        chk("valid4", int'(vp4), int'(ev[0]));
        chk("end4",   int'(ep4), int'(ee[0]));
        chk("pool4",  int'(pool4), int'(ep[0]));
        chk("valid5", int'(vp5), int'(ev[1]));
        chk("end5",   int'(ep5), int'(ee[1]));
        chk("pool5",  int'(pool5), int'(ep[1]));
    endtask

    // One cycle: check what the previous edge produced, then drive new inputs.
    task automatic cyc(input logic a4, input logic a5, input logic c, input logic e,
                       input logic [7:0] x);
        @(negedge clk);
        check_outputs();
        v4 = a4; v5 = a5; ce = c; end_in = e; din = x;
        model_edge(0, 4, a4, c, e, x);
        model_edge(1, 5, a5, c, e, x);
    endtask

    task automatic idle(input int k);
        for (int i = 0; i < k; i++) cyc(1'b0, 1'b0, 1'b1, 1'b0, 8'h00);
    endtask

    task automatic clrq();
        @(posedge clk);
        #1;
        q4.delete();
        q5.delete();
    endtask

    task automatic check_q(input string nm, input logic [8:0] q [$],
                           input int e0, input int e1, input int e2, input int e3);
        int e [4];
        e[0] = e0; e[1] = e1; e[2] = e2; e[3] = e3;
        chk({nm, "_count"}, q.size(), 4);
        for (int i = 0; i < 4 && i < q.size(); i++)
            chk({nm, "_result"}, int'(q[i]), ((i == 3) ? 256 : 0) + e[i]);
    endtask

    task automatic ramp4();
        for (int i = 0; i < 16; i++) cyc(1'b1, 1'b0, 1'b1, 1'b0, 8'(i));
    endtask

    initial begin
        #1_000_000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1);
    end

    initial begin
        for (int m = 0; m < 4; m++) begin
            for (int i = 0; i < 16; i++) begin
                int r, c;
                r = i / 4;
                c = i % 4;
                tbl[m*16+i].ev = (i == 5) || (i == 7) || (i == 13) || (i == 15);
                tbl[m*16+i].ee = (i == 15);
                case (m)
                    2: begin
                        tbl[m*16+i].d  = (r % 2 == 0 && c % 2 == 0) ? 8'h7F : 8'h80;
                        tbl[m*16+i].ep = 8'h7F;
                    end
                    3: begin
                        tbl[m*16+i].d = 8'hFF;
`ifdef MAX_POOLER_RELU_EN
                        tbl[m*16+i].ep = 8'h00;
`else
                        tbl[m*16+i].ep = 8'hFF;
`endif
                    end
                    default: begin
                        tbl[m*16+i].d  = 8'(i);
                        tbl[m*16+i].ep = 8'(i);
                    end
                endcase
            end
        end

        rst = 1'b0; ce = 1'b0; end_in = 1'b0; v4 = 1'b0; v5 = 1'b0; din = 8'h00;
        model_reset();
        #2 rst = 1'b1;
        #1;
        chk("reset_pool4",  int'(pool4), 0);
        chk("reset_valid4", int'(vp4), 0);
        chk("reset_end4",   int'(ep4), 0);
        chk("reset_pool5",  int'(pool5), 0);
        @(negedge clk);
        rst = 1'b0;
        idle(2);

        // Table: two ramps, signed 0x80/0x7F mix, all 0xFF on the N=4 instance.
        for (int i = 0; i < 64; i++) begin
            cyc(1'b1, 1'b0, 1'b1, 1'b0, tbl[i].d);
            @(posedge clk);
            #1;
            chk("tbl_valid", int'(vp4), int'(tbl[i].ev));
            chk("tbl_end",   int'(ep4), int'(tbl[i].ee));
            if (tbl[i].ev) chk("tbl_pool", int'(pool4), int'(tbl[i].ep));
        end
        idle(2);

        // N=5 floor mode, twice to confirm restart at (0,0).
        for (int rep = 0; rep < 2; rep++) begin
            clrq();
            for (int i = 0; i < 25; i++) cyc(1'b0, 1'b1, 1'b1, 1'b0, 8'(i));
            idle(3);
            @(posedge clk); #1;
            check_q("n5_ramp", q5, 6, 8, 16, 18);
        end

        // Gaps in valid_in and a 3-cycle ce stall mid-row.
        clrq();
        begin
            int i, k;
            i = 0; k = 0;
            while (i < 16) begin
                logic a, c;
                a = (k % 2 == 0);
                c = !(k >= 9 && k <= 11);
                cyc(a, 1'b0, c, 1'b0, a ? 8'(i) : 8'hEE);
                if (a && c) i++;
                k++;
            end
        end
        idle(3);
        @(posedge clk); #1;
        check_q("gaps", q4, 5, 7, 13, 15);

        // Asynchronous reset after 6 samples.
        for (int i = 0; i < 6; i++) cyc(1'b1, 1'b0, 1'b1, 1'b0, 8'(i + 40));
        @(negedge clk);
        check_outputs();
        v4 = 1'b0;
        rst = 1'b1;
        #1;
        chk("midreset_pool4",  int'(pool4), 0);
        chk("midreset_valid4", int'(vp4), 0);
        model_reset();
        @(negedge clk);
        rst = 1'b0;
        clrq();
        ramp4();
        idle(3);
        @(posedge clk); #1;
        check_q("after_reset", q4, 5, 7, 13, 15);

        // end_in resync after a truncated map; data on the end_in cycle is dropped.
        for (int i = 0; i < 6; i++) cyc(1'b1, 1'b0, 1'b1, 1'b0, 8'(i + 60));
        cyc(1'b1, 1'b0, 1'b1, 1'b1, 8'h7E);
        idle(2);
        clrq();
        ramp4();
        idle(3);
        @(posedge clk); #1;
        check_q("after_end", q4, 5, 7, 13, 15);

        // Randomized traffic on both instances against the model.
        for (int i = 0; i < 700; i++) begin
            cyc(($urandom % 4) != 0, ($urandom % 4) != 0, ($urandom % 8) != 0,
                ($urandom % 80) == 0, 8'($urandom));
        end
        idle(2);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
`default_nettype wire

// File: doc/max_pooler.md
# max_pooler

Streaming P×P max-pooling stage directly downstream of `convolver`. Consumes the row-major convolution output stream (`conv_op`/`valid_conv`) of one N×N feature map, one sample per cycle at most, and emits the (N/P)×(N/P) pooled map in row-major order. A line buffer of N/P partial maxima avoids storing whole rows; there is no backpressure.

## Interface
- `dataWidth`, 8: sample width, signed two's complement.
- `N`, 56: input map width and height; equals convolver `W-K+1`.
- `P`, 2: pooling window size and stride; 2 ≤ P ≤ N.
- `clk`  in  1  clock; all state changes on rising edge.
- `global_rst`  in  1  asynchronous, active-high reset.
- `ce`  in  1  clock enable; when low, no state changes except `valid_pool`/`end_pool` clearing.
- `valid_in`  in  1  sample valid; driven from convolver `valid_conv`.
- `end_in`  in  1  frame resync; driven from convolver `end_conv`.
- `data_in`  in  dataWidth  input sample (`conv_op`).
- `pool_op`  out  dataWidth  pooled result, registered, held between results.
- `valid_pool`  out  1  one-cycle pulse: `pool_op` is new.
- `end_pool`  out  1  one-cycle pulse coincident with the last `valid_pool` of a map.

## Operation
- Sample accepted when `ce && valid_in && !end_in`.
- Counters `col`, `row` (0..N-1) track position of each accepted sample; `col` wraps to 0 and `row` increments after col N-1; after row N-1, col N-1 both return to 0 (ready for the next map, no idle cycle needed).
- Floor mode: samples with `col ≥ (N/P)*P` or `row ≥ (N/P)*P` are accepted (counters advance) but never contribute to a result.
- Horizontal max `hmax`: loaded at `col%P==0`, updated with signed max otherwise.
- At `col%P==P-1` (window column complete), with `w = col/P` and combined value `m = max(hmax, data_in)`:
  - `row%P==0`: `lbuf[w] <= m`.
  - `0 < row%P < P-1`: `lbuf[w] <= max(lbuf[w], m)`.
  - `row%P==P-1`: `pool_op <= max(lbuf[w], m)`, `valid_pool <= 1`.
- `end_pool <= 1` with the result at window row N/P-1, column N/P-1.
- All comparisons signed, full dataWidth; no width growth.
- `ce && end_in`: counters and `hmax` cleared at next edge; any `data_in` that cycle discarded; no output produced. Used to resync after a truncated map.
- `lbuf` contents need no reset: always written on window row 0 before being read.

## Timing
- Reset values: `pool_op`=0, `valid_pool`=0, `end_pool`=0, `col`=0, `row`=0, `hmax`=0.
- Reset mid-map: all above return to reset values immediately (asynchronous); partial map discarded, next accepted sample is (0,0).
- Latency: `valid_pool` rises at the edge that accepts the window's final sample (bottom-right), i.e. visible the cycle after that sample is presented.
- `valid_pool`/`end_pool` deassert at the next edge regardless of `ce`.
- Gaps in `valid_in` or `ce` are allowed anywhere; results are independent of gap pattern.
- Throughput: one sample per cycle; at most one result per P accepted samples.

## Configuration
- `MAX_POOLER_RELU_EN` defined: each accepted `data_in` is clamped to 0 if negative before any comparison; `pool_op` is never negative.
- Not defined: raw signed values pooled; negative results pass through.

## Test plan
- N=4, P=2, ramp 0..15 back-to-back -> `pool_op` 5, 7, 13, 15 with one `valid_pool` each; `end_pool` only with 15; then second identical map -> same four results.
- N=5, P=2, ramp 0..24 -> results 6, 8, 16, 18; `end_pool` with 18; column 4/row 4 samples produce nothing; next map restarts at (0,0).
- N=4, P=2, ramp 0..15 with `valid_in` low every other cycle and `ce` low for 3 cycles mid-row -> results 5, 7, 13, 15 unchanged.
- N=4, P=2, map of 0x80 and 0x7F mixed, every window containing 0x7F -> all results 0x7F (signed compare); map of all 0xFF -> 0xFF without `MAX_POOLER_RELU_EN`, 0x00 with it.
- N=4, P=2, assert `global_rst` after 6 samples, then full ramp 0..15 -> outputs reset to 0 immediately, then 5, 7, 13, 15.
- N=4, P=2, `end_in` pulse after 6 samples, then ramp 0..15 -> no output from partial data; results 5, 7, 13, 15.
